// File: rtl/ball_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ball_controller
// Brief    : Frame-rate ball and serve FSM for breakout. Define
//            BALL_AUTOSERVE_EN to enable the auto-serve timeout.
// Revision : 1.0  initial release
// ============================================================================
module ball_controller #(
    parameter int LEFT_INNER_X  = 8,
    parameter int RIGHT_INNER_X = 792,
    parameter int CEIL_INNER_Y  = 8,
    parameter int PADDLE_Y      = 560,
    parameter int PADDLE_LEN    = 64,
    parameter int BALL_SIZE     = 8,
    parameter int SPEED         = 2,
    parameter int LOST_Y        = 600,
    parameter int LOST_FRAMES   = 60,
    parameter int SERVE_FRAMES  = 120
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FRAME_DONE,
    input  logic [9:0] PADDLE_X_PIXEL,
    input  logic       LAUNCH,
    output logic [9:0] BALL_X_PIXEL,
    output logic [9:0] BALL_Y_PIXEL,
    output logic       BALL_LOST,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_LOST  = 2'd2
    } state_t;

    localparam int c_cnt_max = (LOST_FRAMES > SERVE_FRAMES) ? LOST_FRAMES : SERVE_FRAMES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [10:0] c_left       = 11'(LEFT_INNER_X);
    localparam logic [10:0] c_right      = 11'(RIGHT_INNER_X);
    localparam logic [10:0] c_ceil       = 11'(CEIL_INNER_Y);
    localparam logic [10:0] c_paddle_y   = 11'(PADDLE_Y);
    localparam logic [10:0] c_paddle_len = 11'(PADDLE_LEN);
    localparam logic [10:0] c_ball       = 11'(BALL_SIZE);
    localparam logic [10:0] c_speed      = 11'(SPEED);
    localparam logic [10:0] c_lost_y     = 11'(LOST_Y);
    localparam logic [9:0]  c_right_stop = 10'(RIGHT_INNER_X - BALL_SIZE);
    localparam logic [9:0]  c_serve_off  = 10'(PADDLE_LEN / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  c_serve_y    = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0]  c_rst_x      = 10'((LEFT_INNER_X + RIGHT_INNER_X - BALL_SIZE) / 2);
    localparam logic [c_cnt_w-1:0] c_lost_last = c_cnt_w'(LOST_FRAMES - 1);

    state_t             state_q, state_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic               lost_q, lost_d;
    logic               armed_q, armed_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    logic        w_tick, w_go, w_paddle_hit;
    logic [10:0] w_x, w_y, w_px;
    logic [10:0] w_x_dec, w_x_inc, w_x_inc_far;
    logic [10:0] w_y_dec, w_y_inc, w_y_bot, w_y_bot_inc;
    logic [9:0]  w_serve_x, w_play_x, w_play_y;
    logic        w_play_dx, w_play_dy, w_play_lost;

    // armed_q stays low for the first edge after reset release, so a frame
    // pulse landing on that edge cannot move the ball.
    assign w_tick = FRAME_DONE & armed_q;

    assign w_x         = {1'b0, x_q};
    assign w_y         = {1'b0, y_q};
    assign w_px        = {1'b0, PADDLE_X_PIXEL};
    assign w_serve_x   = PADDLE_X_PIXEL + c_serve_off;
    assign w_x_dec     = w_x - c_speed;
    assign w_x_inc     = w_x + c_speed;
    assign w_x_inc_far = w_x_inc + c_ball;
    assign w_y_dec     = w_y - c_speed;
    assign w_y_inc     = w_y + c_speed;
    assign w_y_bot     = w_y + c_ball;
    assign w_y_bot_inc = w_y_bot + c_speed;

    assign w_paddle_hit = (w_y_bot <= c_paddle_y) && (w_y_bot_inc > c_paddle_y) &&
                          (w_x + c_ball > w_px) && (w_x < w_px + c_paddle_len);

`ifdef BALL_AUTOSERVE_EN
    localparam logic [c_cnt_w-1:0] c_serve_last = c_cnt_w'(SERVE_FRAMES - 1);
    assign w_go = LAUNCH | (cnt_q == c_serve_last);
`else
    assign w_go = LAUNCH;
`endif

    // One PLAY step; both axes resolve independently so corners reflect twice.
    always_comb begin
        w_play_x    = x_q;
        w_play_dx   = dx_q;
        w_play_y    = y_q;
        w_play_dy   = dy_q;
        w_play_lost = 1'b0;
        if (dx_q) begin
            if (w_x_inc_far > c_right) begin
                w_play_x  = c_right_stop;
                w_play_dx = 1'b0;
            end else begin
                w_play_x = w_x_inc[9:0];
            end
        end else begin
            if (w_x_dec < c_left) begin
                w_play_x  = c_left[9:0];
                w_play_dx = 1'b1;
            end else begin
                w_play_x = w_x_dec[9:0];
            end
        end
        if (!dy_q) begin
            if (w_y_dec < c_ceil) begin
                w_play_y  = c_ceil[9:0];
                w_play_dy = 1'b1;
            end else begin
                w_play_y = w_y_dec[9:0];
            end
        end else if (w_paddle_hit) begin
            w_play_y  = c_serve_y;
            w_play_dy = 1'b0;
        end else if (w_y_inc >= c_lost_y) begin
            w_play_lost = 1'b1;
            w_play_x    = x_q;
            w_play_dx   = dx_q;
            w_play_y    = c_lost_y[9:0];
        end else begin
            w_play_y = w_y_inc[9:0];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cnt_d   = cnt_q;
        lost_d  = 1'b0;
        armed_d = 1'b1;
        if (w_tick) begin
            case (state_q)
                ST_SERVE: begin
                    x_d = w_serve_x;
                    y_d = c_serve_y;
                    if (w_go) begin
                        state_d = ST_PLAY;
                        dx_d    = 1'b1;
                        dy_d    = 1'b0;
                        cnt_d   = '0;
                    end
`ifdef BALL_AUTOSERVE_EN
                    else begin
                        cnt_d = cnt_q + c_cnt_w'(1);
                    end
`endif
                end
                ST_PLAY: begin
                    x_d  = w_play_x;
                    y_d  = w_play_y;
                    dx_d = w_play_dx;
                    dy_d = w_play_dy;
                    if (w_play_lost) begin
                        state_d = ST_LOST;
                        lost_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
                ST_LOST: begin
                    if (cnt_q == c_lost_last) begin
                        state_d = ST_SERVE;
                        cnt_d   = '0;
                        x_d     = w_serve_x;
                        y_d     = c_serve_y;
                    end else begin
                        cnt_d = cnt_q + c_cnt_w'(1);
                    end
                end
                default: begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_SERVE;
            x_q     <= c_rst_x;
            y_q     <= c_serve_y;
            dx_q    <= 1'b1;
            dy_q    <= 1'b0;
            lost_q  <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            lost_q  <= lost_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BALL_X_PIXEL = x_q;
    assign BALL_Y_PIXEL = y_q;
    assign BALL_LOST    = lost_q;
    assign STATE        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ball_controller
// Brief    : Scoreboard bench for ball_controller; follows BALL_AUTOSERVE_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_ball_controller;

    localparam int LEFT_INNER_X  = 8;
    localparam int RIGHT_INNER_X = 792;
    localparam int CEIL_INNER_Y  = 8;
    localparam int PADDLE_Y      = 560;
    localparam int PADDLE_LEN    = 64;
    localparam int BALL_SIZE     = 8;
    localparam int SPEED         = 2;
    localparam int LOST_Y        = 600;
    localparam int LOST_FRAMES   = 60;
    localparam int SERVE_FRAMES  = 120;
`ifdef BALL_AUTOSERVE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       FRAME_DONE = 1'b0;
    logic       LAUNCH = 1'b0;
    logic [9:0] PADDLE_X_PIXEL = '0;
    logic [9:0] BALL_X_PIXEL, BALL_Y_PIXEL;
    logic       BALL_LOST;
    logic [1:0] STATE;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {int x; int y; int st; int lost;} exp_t;
    exp_t sb_q[$];

    int m_x, m_y, m_dx, m_dy, m_state, m_cnt, m_lost;

    ball_controller #(
        .LEFT_INNER_X(LEFT_INNER_X), .RIGHT_INNER_X(RIGHT_INNER_X),
        .CEIL_INNER_Y(CEIL_INNER_Y), .PADDLE_Y(PADDLE_Y), .PADDLE_LEN(PADDLE_LEN),
        .BALL_SIZE(BALL_SIZE), .SPEED(SPEED), .LOST_Y(LOST_Y),
        .LOST_FRAMES(LOST_FRAMES), .SERVE_FRAMES(SERVE_FRAMES)
    ) u_dut (
        .CLK(CLK), .RESET(RESET), .FRAME_DONE(FRAME_DONE),
        .PADDLE_X_PIXEL(PADDLE_X_PIXEL), .LAUNCH(LAUNCH),
        .BALL_X_PIXEL(BALL_X_PIXEL), .BALL_Y_PIXEL(BALL_Y_PIXEL),
        .BALL_LOST(BALL_LOST), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = (LEFT_INNER_X + RIGHT_INNER_X - BALL_SIZE) / 2;
        m_y = PADDLE_Y - BALL_SIZE;
        m_dx = 1; m_dy = 0; m_state = 0; m_cnt = 0; m_lost = 0;
        sb_q.delete();
    endtask

    // Reference behaviour for one frame tick; pushes the expected outputs.
    task automatic model_tick(input int launch, input int px);
        int nx, ndx, ny, ndy;
        bit go, hit;
        m_lost = 0;
        case (m_state)
            0: begin
                m_x = px + PADDLE_LEN / 2 - BALL_SIZE / 2;
                m_y = PADDLE_Y - BALL_SIZE;
                go = (launch != 0) || (AUTO && m_cnt == SERVE_FRAMES - 1);
                if (go) begin
                    m_state = 1; m_dx = 1; m_dy = 0; m_cnt = 0;
                end else if (AUTO) begin
                    m_cnt++;
                end
            end
            1: begin
                nx = m_x; ndx = m_dx; ny = m_y; ndy = m_dy;
                if (m_dx != 0) begin
                    if (m_x + SPEED + BALL_SIZE > RIGHT_INNER_X) begin
                        nx = RIGHT_INNER_X - BALL_SIZE; ndx = 0;
                    end else nx = m_x + SPEED;
                end else begin
                    if (m_x - SPEED < LEFT_INNER_X) begin
                        nx = LEFT_INNER_X; ndx = 1;
                    end else nx = m_x - SPEED;
                end
                if (m_dy == 0) begin
                    if (m_y - SPEED < CEIL_INNER_Y) begin
                        ny = CEIL_INNER_Y; ndy = 1;
                    end else ny = m_y - SPEED;
                end else begin
                    hit = (m_y + BALL_SIZE <= PADDLE_Y) && (m_y + BALL_SIZE + SPEED > PADDLE_Y) &&
                          (m_x + BALL_SIZE > px) && (m_x < px + PADDLE_LEN);
                    if (hit) begin
                        ny = PADDLE_Y - BALL_SIZE; ndy = 0;
                    end else if (m_y + SPEED >= LOST_Y) begin
                        m_lost = 1;
                    end else ny = m_y + SPEED;
                end
                if (m_lost != 0) begin
                    m_state = 2; m_y = LOST_Y; m_cnt = 0;
                end else begin
                    m_x = nx; m_dx = ndx; m_y = ny; m_dy = ndy;
                end
            end
            default: begin
                if (m_cnt == LOST_FRAMES - 1) begin
                    m_cnt = 0; m_state = 0;
                    m_x = px + PADDLE_LEN / 2 - BALL_SIZE / 2;
                    m_y = PADDLE_Y - BALL_SIZE;
                end else m_cnt++;
            end
        endcase
        sb_q.push_back('{m_x, m_y, m_state, m_lost});
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        check_value({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_value({tag, "_x"}, BALL_X_PIXEL, e.x);
            check_value({tag, "_y"}, BALL_Y_PIXEL, e.y);
            check_value({tag, "_state"}, STATE, e.st);
            check_value({tag, "_lost"}, BALL_LOST, e.lost);
        end
    endtask

    // One tick, then an idle cycle that must hold position and drop BALL_LOST.
    task automatic drive_tick(input int launch, input int px);
        @(negedge CLK);
        FRAME_DONE = 1'b1;
        LAUNCH = (launch != 0);
        PADDLE_X_PIXEL = 10'(px);
        model_tick(launch, px);
        @(negedge CLK);
        FRAME_DONE = 1'b0;
        LAUNCH = 1'b0;
        compare_out("tick");
        @(negedge CLK);
        check_value("idle_x", BALL_X_PIXEL, m_x);
        check_value("idle_y", BALL_Y_PIXEL, m_y);
        check_value("idle_lost", BALL_LOST, 0);
    endtask

    task automatic drive_burst(input int px);
        @(negedge CLK);
        FRAME_DONE = 1'b1;
        PADDLE_X_PIXEL = 10'(px);
        model_tick(0, px);
        @(negedge CLK);
        compare_out("burst1");
        model_tick(0, px);
        @(negedge CLK);
        FRAME_DONE = 1'b0;
        compare_out("burst2");
    endtask

    task automatic run_track(input int n);
        int px;
        for (int i = 0; i < n; i++) begin
            px = m_x - int'($urandom_range(0, 56));
            if (px < 0) px = 0;
            if (i == n / 2) drive_burst(px);
            else drive_tick(0, px);
        end
    endtask

    task automatic run_miss();
        int guard = 0;
        while (m_state != 2 && guard < 1500) begin
            drive_tick(0, (m_x < 400) ? 700 : 0);
            guard++;
        end
        check_value("miss_state", STATE, 2);
    endtask

    task automatic run_lost(input int px);
        for (int k = 1; k <= LOST_FRAMES; k++) begin
            drive_tick(0, px);
            if (k == LOST_FRAMES - 1) check_value("lost_hold_state", STATE, 2);
        end
        check_value("lost_exit_state", STATE, 0);
    endtask

    task automatic reset_release_ignored();
        @(negedge CLK);
        RESET = 1'b0;
        FRAME_DONE = 1'b1;
        PADDLE_X_PIXEL = 10'd100;
        @(negedge CLK);
        FRAME_DONE = 1'b0;
        check_value("rel_ign_x", BALL_X_PIXEL, 396);
        check_value("rel_ign_y", BALL_Y_PIXEL, 552);
        check_value("rel_ign_state", STATE, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge CLK);
        check_value("rst_x", BALL_X_PIXEL, 396);
        check_value("rst_y", BALL_Y_PIXEL, 552);
        check_value("rst_state", STATE, 0);
        check_value("rst_lost", BALL_LOST, 0);
        reset_release_ignored();

        drive_tick(0, 100);
        check_value("serve_x", BALL_X_PIXEL, 128);
        check_value("serve_y", BALL_Y_PIXEL, 552);
        for (int k = 0; k < 10; k++) drive_tick(0, 100);
        check_value("serve_wait_state", STATE, 0);

        // A launch level between ticks must not be seen.
        @(negedge CLK);
        LAUNCH = 1'b1;
        @(negedge CLK);
        LAUNCH = 1'b0;
        drive_tick(0, 100);
        check_value("glitch_launch_state", STATE, 0);

        drive_tick(1, 100);
        check_value("launch_state", STATE, 1);
        check_value("launch_x", BALL_X_PIXEL, 128);
        drive_tick(0, 100);
        check_value("play1_x", BALL_X_PIXEL, 130);
        check_value("play1_y", BALL_Y_PIXEL, 550);
        drive_tick(0, 100);
        check_value("play2_x", BALL_X_PIXEL, 132);
        check_value("play2_y", BALL_Y_PIXEL, 548);

        run_track(1400);
        run_miss();
        run_lost(101);
        check_value("reserve_x", BALL_X_PIXEL, 129);

        drive_tick(1, 101);
        run_track(1400);
        run_miss();
        run_lost(300);

`ifdef BALL_AUTOSERVE_EN
        for (int k = 0; k < SERVE_FRAMES - 1; k++) drive_tick(0, 300);
        check_value("auto_wait_state", STATE, 0);
        drive_tick(0, 300);
        check_value("auto_launch_state", STATE, 1);
`else
        for (int k = 0; k < 150; k++) drive_tick(0, 300);
        check_value("manual_wait_state", STATE, 0);
        drive_tick(1, 300);
        check_value("manual_launch_state", STATE, 1);
`endif
        for (int k = 0; k < 20; k++) drive_tick(0, 300);

        // Asynchronous abort in the middle of PLAY.
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check_value("midrst_x", BALL_X_PIXEL, 396);
        check_value("midrst_y", BALL_Y_PIXEL, 552);
        check_value("midrst_state", STATE, 0);
        check_value("midrst_lost", BALL_LOST, 0);
        model_reset();
        repeat (2) @(negedge CLK);
        reset_release_ignored();
        drive_tick(0, 100);
        check_value("post_rst_serve_x", BALL_X_PIXEL, 128);
        check_value("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
